// File: rtl/wash_sequencer_if.sv
// Front-panel / display bundle of the wash sequencer.
// The master drives the key and tick inputs.
// The slave (the sequencer) drives the display and actuator outputs.
interface wash_sequencer_if;
    logic       tick;
    logic       Power;
    logic       start_pause;
    logic [1:0] rinse_cnt;
    logic [7:0] water_level;
    logic [7:0] c_time;
    logic [7:0] a_time;
    logic [7:0] ct_time;
    logic       Auto_End;
    logic [2:0] state;
    logic       valve_in;
    logic       valve_out;
    logic       motor;

    modport master (
        output tick, Power, start_pause, rinse_cnt,
        input  water_level, c_time, a_time, ct_time, Auto_End, state,
               valve_in, valve_out, motor
    );

    modport slave (
        input  tick, Power, start_pause, rinse_cnt,
        output water_level, c_time, a_time, ct_time, Auto_End, state,
               valve_in, valve_out, motor
    );
endinterface

// File: rtl/wash_sequencer.sv
// One wash programme sequenced off a 1 s tick.
// The programme runs fill, agitate, drain, then optional rinse loops, spin, and an end hold.
// All outputs come straight from flops. The programme-time output is kept saturated in its
// own register, so no combinational path reaches the display.
module wash_sequencer #(
    parameter int unsigned WATER_MAX = 10,
    parameter int unsigned WASH_T    = 20,
    parameter int unsigned RINSE_T   = 10,
    parameter int unsigned SPIN_T    = 8,
    parameter int unsigned END_HOLD  = 10
) (
    input logic             clk,
    input logic             rst,
    wash_sequencer_if.slave bus
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FILL   = 3'd1,
        ST_AGIT   = 3'd2,
        ST_DRAIN  = 3'd3,
        ST_SPIN   = 3'd4,
        ST_DONE   = 3'd5,
        ST_PAUSED = 3'd6
    } state_t;

    localparam logic [7:0] WMAX_C  = 8'(WATER_MAX);
    localparam logic [7:0] WASH_C  = 8'(WASH_T);
    localparam logic [7:0] RINSE_C = 8'(RINSE_T);
    localparam logic [7:0] SPIN_C  = 8'(SPIN_T);
    localparam logic [7:0] HOLD_C  = 8'(END_HOLD);

    // Total ticks of a programme with r rinses: every fill and drain moves WATER_MAX units.
    function automatic logic [8:0] programme_time(input logic [1:0] r);
        logic [8:0] r9;
        r9 = {7'd0, r};
        return (r9 + 9'd1) * 9'd2 * 9'(WATER_MAX) + 9'(WASH_T) + r9 * 9'(RINSE_T) + 9'(SPIN_T);
    endfunction

    // The display front-end only has two digits.
    function automatic logic [7:0] sat99(input logic [8:0] v);
        return (v > 9'd99) ? 8'd99 : v[7:0];
    endfunction

    // Actuator pattern {valve_in, valve_out, motor} for a running phase.
    function automatic logic [2:0] actuators(input state_t s);
        case (s)
            ST_FILL:          return 3'b100;
            ST_DRAIN:         return 3'b010;
            ST_AGIT, ST_SPIN: return 3'b001;
            default:          return 3'b000;
        endcase
    endfunction

    state_t      state_r;
    state_t      saved_r;
    logic [1:0]  rinse_total_r;
    logic [1:0]  rinses_done_r;
    logic [7:0]  water_r;
    logic [7:0]  c_time_r;
    logic [8:0]  a_time_r;
    logic [7:0]  a_time_out_r;
    logic [7:0]  ct_time_r;
    logic        auto_end_r;
    logic [2:0]  act_r;

    logic [7:0]  water_inc_s;
    logic [7:0]  water_dec_s;
    logic [7:0]  c_dec_s;
    logic [7:0]  ct_dec_s;
    logic [8:0]  a_dec_s;

    // Saturating next values of the counters for the current tick.
    always_comb begin
        water_inc_s = water_r + 8'd1;
        water_dec_s = (water_r   != 8'd0) ? water_r   - 8'd1 : 8'd0;
        c_dec_s     = (c_time_r  != 8'd0) ? c_time_r  - 8'd1 : 8'd0;
        ct_dec_s    = (ct_time_r != 8'd0) ? ct_time_r - 8'd1 : 8'd0;
        a_dec_s     = (a_time_r  != 9'd0) ? a_time_r  - 9'd1 : 9'd0;
    end

    // Programme sequencer: power-off, then keys, then ticks, in that priority order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst || !bus.Power) begin
            state_r       <= ST_IDLE;
            saved_r       <= ST_IDLE;
            rinse_total_r <= 2'd0;
            rinses_done_r <= 2'd0;
            water_r       <= 8'd0;
            c_time_r      <= 8'd0;
            a_time_r      <= 9'd0;
            a_time_out_r  <= 8'd0;
            ct_time_r     <= 8'd0;
            auto_end_r    <= 1'b0;
            act_r         <= 3'b000;
        end else if (bus.start_pause && (state_r == ST_IDLE || state_r == ST_DONE)) begin
            // New programme; any tick arriving in the same cycle is dropped.
            rinse_total_r <= bus.rinse_cnt;
            rinses_done_r <= 2'd0;
            water_r       <= 8'd0;
            c_time_r      <= WMAX_C;
            a_time_r      <= programme_time(bus.rinse_cnt);
            a_time_out_r  <= sat99(programme_time(bus.rinse_cnt));
            ct_time_r     <= 8'd0;
            auto_end_r    <= 1'b0;
            state_r       <= ST_FILL;
            act_r         <= actuators(ST_FILL);
        end else begin
            case (state_r)
                ST_IDLE: begin
                    state_r <= ST_IDLE;
                end
                ST_DONE: begin
                    if (bus.tick) begin
                        ct_time_r <= ct_dec_s;
                        if (ct_dec_s == 8'd0) begin
                            auto_end_r <= 1'b0;
                            state_r    <= ST_IDLE;
                        end
                    end
                end
                ST_PAUSED: begin
                    if (bus.start_pause) begin
                        state_r <= saved_r;
                        act_r   <= actuators(saved_r);
                    end
                end
                ST_FILL, ST_AGIT, ST_DRAIN, ST_SPIN: begin
                    if (bus.start_pause) begin
                        saved_r <= state_r;
                        state_r <= ST_PAUSED;
                        act_r   <= 3'b000;
                    end else if (bus.tick) begin
                        a_time_r     <= a_dec_s;
                        a_time_out_r <= sat99(a_dec_s);
                        case (state_r)
                            ST_FILL: begin
                                water_r <= water_inc_s;
                                if (water_inc_s >= WMAX_C) begin
                                    c_time_r <= (rinses_done_r == 2'd0) ? WASH_C : RINSE_C;
                                    state_r  <= ST_AGIT;
                                    act_r    <= actuators(ST_AGIT);
                                end else begin
                                    c_time_r <= WMAX_C - water_inc_s;
                                end
                            end
                            ST_AGIT: begin
                                if (c_dec_s == 8'd0) begin
                                    c_time_r <= water_r;
                                    state_r  <= ST_DRAIN;
                                    act_r    <= actuators(ST_DRAIN);
                                end else begin
                                    c_time_r <= c_dec_s;
                                end
                            end
                            ST_DRAIN: begin
                                water_r <= water_dec_s;
                                if (water_dec_s != 8'd0) begin
                                    c_time_r <= water_dec_s;
                                end else if (rinses_done_r < rinse_total_r) begin
                                    rinses_done_r <= rinses_done_r + 2'd1;
                                    c_time_r      <= WMAX_C;
                                    state_r       <= ST_FILL;
                                    act_r         <= actuators(ST_FILL);
                                end else begin
                                    c_time_r <= SPIN_C;
                                    state_r  <= ST_SPIN;
                                    act_r    <= actuators(ST_SPIN);
                                end
                            end
                            ST_SPIN: begin
                                if (c_dec_s == 8'd0) begin
                                    c_time_r     <= 8'd0;
                                    a_time_r     <= 9'd0;
                                    a_time_out_r <= 8'd0;
                                    ct_time_r    <= HOLD_C;
                                    auto_end_r   <= 1'b1;
                                    state_r      <= ST_DONE;
                                    act_r        <= 3'b000;
                                end else begin
                                    c_time_r <= c_dec_s;
                                end
                            end
                            default: begin
                                state_r <= ST_IDLE;
                            end
                        endcase
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    act_r   <= 3'b000;
                end
            endcase
        end
    end

    assign bus.water_level = water_r;
    assign bus.c_time      = c_time_r;
    assign bus.a_time      = a_time_out_r;
    assign bus.ct_time     = ct_time_r;
    assign bus.Auto_End    = auto_end_r;
    assign bus.state       = state_r;
    assign bus.valve_in    = act_r[2];
    assign bus.valve_out   = act_r[1];
    assign bus.motor       = act_r[0];

endmodule
